periph_bus_arbiter: RTL
=======================

Name: periph_bus_arbiter

Overview:
- Two-master arbiter and sequencer for the shared memory-mapped peripheral bus.
- The bus signals are data[63:0] inout, address[31:0], mem_read, mem_write and size[1:0]; GPIO and the other peripherals hang off this bus.
- Master 0 is the CPU load/store unit; master 1 is the DMA/debug port.
- Per transaction the block grants one master round-robin, latches its request, drives one fixed-length bus access, and returns read data plus a one-cycle done pulse.

Parameters:
- ACCESS_CYCLES, 1: cycles mem_read/mem_write are held asserted per transaction; legal range 1..15.
- WIN_BASE, 32'h00000000: base of the legal peripheral address window (used only with the optional feature).
- WIN_MASK, 32'hFFFFFF00: mask applied to the address before comparing against WIN_BASE.

Ports:
- clock  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0, req1  in  1 each  transaction request from master 0 / master 1.
- addr0, addr1  in  32 each  request address.
- wdata0, wdata1  in  64 each  write data.
- write0, write1  in  1 each  1 = write, 0 = read.
- size0, size1  in  2 each  00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 = 64-bit.
- gnt0, gnt1  out  1 each  one-cycle grant pulse.
- done0, done1  out  1 each  one-cycle completion pulse.
- err0, err1  out  1 each  bus error, valid with done.
- rdata  out  64  read data, valid in the done cycle, held until the next done.
- address  out  32  shared bus address.
- mem_read, mem_write  out  1 each  shared bus strobes.
- size  out  2  shared bus size.
- data  inout  64  shared bus data.

Behaviour:
- Reset, applied asynchronously:
  - State = IDLE; gnt*, done*, err*, mem_read, mem_write = 0.
  - address = 0, size = 0, rdata = 0, data = high-Z.
  - last_grant = 1, so master 0 wins the first contention.
  - Reset asserted mid-transaction aborts it: no done, and the bus is released immediately.
- States: IDLE, ACCESS, DONE. All outputs are registered.
- IDLE:
  - If no req is high at the rising edge, stay in IDLE.
  - If exactly one req is high, grant it.
  - If both are high, grant the master other than last_grant.
  - On a grant: latch that master's addr, wdata, write and size; set last_grant; load cnt = ACCESS_CYCLES-1; go to ACCESS.
- ACCESS:
  - address and size = latched values.
  - mem_write = latched write; mem_read = ~latched write. Never both high.
  - data = latched wdata when writing, else high-Z.
  - gntN = 1 only in the first ACCESS cycle.
  - cnt decrements each cycle. At the edge ending the cycle with cnt == 0:
    - On a read, capture data into rdata, zero-extended per size: 00 -> {56'b0, data[7:0]}, 01 -> {48'b0, data[15:0]}, 10 -> {32'b0, data[31:0]}, 11 -> data.
    - Go to DONE.
- DONE:
  - Strobes deasserted, data = high-Z, address and size hold.
  - doneN = 1 for exactly one cycle; next state IDLE.
  - On a write, rdata is unchanged.
- Latency:
  - req sampled at edge k -> first ACCESS cycle starts at k, done at edge k+ACCESS_CYCLES.
  - Minimum 2 edges from one grant to the next.
- Master rule:
  - Fields need be stable only at the sampling edge.
  - req must be low by the edge after done, or a new transaction is started.
  - A req that stays high across IDLE counts as a new request.
- Fairness: under continuous contention, grants alternate 0,1,0,1. A lone requester is granted back-to-back.
- Requests arriving during ACCESS/DONE wait; they are not dropped while req stays high.

Optional Feature:
- Macro: PBA_BUSERR_EN.
- Defined: at grant, if (latched addr & WIN_MASK) != WIN_BASE:
  - Skip ACCESS entirely; strobes stay low and data stays high-Z.
  - Go straight to DONE with errN = 1 and rdata = 0.
  - gntN still pulses in the DONE cycle.
- Not defined: err0 and err1 are tied 0 and every request is issued on the bus.

Test Plan:
- Master 0 write, ACCESS_CYCLES = 1: addr0 = 0x08, wdata0 = 0x00000000_0000A5A5, size 01 -> one cycle with mem_write = 1, address = 0x08, data = 0x...A5A5; done0 pulse next cycle; GPIO OUT register reads back 0xA5A5.
- Master 1 read: addr1 = 0x00, size 00, bus data = 0x1234 -> rdata = 0x34 in the done1 cycle; mem_read high for exactly ACCESS_CYCLES.
- req0 and req1 held high for 6 transactions from reset -> grant order 0,1,0,1,0,1; no cycle with both gnt high; no cycle with mem_read and mem_write both high.
- ACCESS_CYCLES = 3 read with reset pulsed in the 2nd ACCESS cycle -> mem_read = 0 and data = Z in the same cycle; no done; next request granted to master 0.
- With PBA_BUSERR_EN, WIN_BASE = 0x100: read at 0x200 -> err0 = 1, rdata = 0, mem_read never asserted. A read at 0x104 completes with err0 = 0.

Source files
------------

// File: rtl/periph_bus_arbiter.sv
// Two-master round-robin arbiter and sequencer for the shared peripheral bus.
// Optional window check enabled by defining PBA_BUSERR_EN.
module periph_bus_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 1,
  parameter logic [31:0] WIN_BASE      = 32'h0000_0000,
  parameter logic [31:0] WIN_MASK      = 32'hFFFF_FF00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [63:0] wdata0,
  input  logic [63:0] wdata1,
  input  logic        write0,
  input  logic        write1,
  input  logic [1:0]  size0,
  input  logic [1:0]  size1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic [63:0] rdata,
  output logic [31:0] address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  size,
  inout  wire  [63:0] data
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t      state, state_nxt;
  logic        last_grant;
  logic [3:0]  cnt;
  logic        data_oe;
  logic [63:0] data_out;

  logic        pick_vld;
  logic        pick;
  logic [31:0] pick_addr;
  logic [63:0] pick_wdata;
  logic        pick_write;
  logic [1:0]  pick_size;
  logic        win_miss;
  logic        win_err;

  assign data = data_oe ? data_out : 64'bz;

  function automatic logic [63:0] zext(input logic [63:0] d, input logic [1:0] s);
    case (s)
      2'b00:   zext = {56'b0, d[7:0]};
      2'b01:   zext = {48'b0, d[15:0]};
      2'b10:   zext = {32'b0, d[31:0]};
      default: zext = d;
    endcase
  endfunction

  // Arbitration: a lone requester always wins; on contention the master
  // that did not win last time goes next.
  always_comb begin
    pick_vld = req0 | req1;
    pick     = 1'b0;
    if (req0 && req1)
      pick = ~last_grant;
    else if (req1)
      pick = 1'b1;
    pick_addr  = pick ? addr1  : addr0;
    pick_wdata = pick ? wdata1 : wdata0;
    pick_write = pick ? write1 : write0;
    pick_size  = pick ? size1  : size0;
    win_miss   = (pick_addr & WIN_MASK) != WIN_BASE;
`ifdef PBA_BUSERR_EN
    win_err    = win_miss;
`else
    win_err    = win_miss & 1'b0;
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = win_err ? DONE : ACCESS;
      ACCESS:  if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Outputs are registered; last_grant doubles as the owner of the
  // in-flight transaction.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
      cnt        <= 4'd0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      err0       <= 1'b0;
      err1       <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      address    <= 32'h0;
      size       <= 2'b00;
      rdata      <= 64'h0;
      data_oe    <= 1'b0;
      data_out   <= 64'h0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      err0  <= 1'b0;
      err1  <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            last_grant <= pick;
            address    <= pick_addr;
            size       <= pick_size;
            data_out   <= pick_wdata;
            gnt0       <= ~pick;
            gnt1       <= pick;
            if (win_err) begin
              done0 <= ~pick;
              done1 <= pick;
              err0  <= ~pick;
              err1  <= pick;
              rdata <= 64'h0;
            end else begin
              cnt       <= CNT_LOAD;
              mem_write <= pick_write;
              mem_read  <= ~pick_write;
              data_oe   <= pick_write;
            end
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            data_oe   <= 1'b0;
            done0     <= ~last_grant;
            done1     <= last_grant;
            if (mem_read)
              rdata <= zext(data, size);
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
